ram_sp_ctrl: RTL and testbench

Parametrised single-port synchronous RAM with a request/valid handshake, per-byte write enables and a selectable read latency of 1 or 2 cycles. A built-in init sequencer zeroes every location after reset or on a soft-clear request. Local scratch/buffer memory for datapath blocks that need a clean, deterministic RAM with a valid-qualified read port instead of a bare array.

---
 rtl/ram_pkg.sv | 18 +
 rtl/ram_sp_ctrl_if.sv | 33 +++
 rtl/ram_core.sv | 61 ++++++
 rtl/ram_sp_ctrl.sv | 149 ++++++++++++++
 tb/tb_ram_sp_ctrl.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_pkg.sv
// Shared types and helpers for the single-port RAM controller.
// RAM_PARITY_EN (optional) adds one even-parity bit per byte lane in storage.
package ram_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int unsigned RD_LAT_MIN = 1;
    localparam int unsigned RD_LAT_MAX = 2;
    localparam int unsigned LANE_W     = 8;

    function automatic logic parity8(input logic [LANE_W-1:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/ram_sp_ctrl_if.sv
// Request/response bus of ram_sp_ctrl.
// RAM_PARITY_EN adds wr_perr_inj and rd_perr to the bus.
interface ram_sp_ctrl_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 10
);
    localparam int unsigned BE_W = DATA_W / 8;

    logic              clr;
    logic              req;
    logic              we;
    logic [BE_W-1:0]   be;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wr_data;
    logic              ready;
    logic              init_done;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
`ifdef RAM_PARITY_EN
    logic              wr_perr_inj;
    logic              rd_perr;

    modport master (output clr, req, we, be, addr, wr_data, wr_perr_inj,
                    input  ready, init_done, rd_valid, rd_data, rd_perr);
    modport slave  (input  clr, req, we, be, addr, wr_data, wr_perr_inj,
                    output ready, init_done, rd_valid, rd_data, rd_perr);
`else
    modport master (output clr, req, we, be, addr, wr_data,
                    input  ready, init_done, rd_valid, rd_data);
    modport slave  (input  clr, req, we, be, addr, wr_data,
                    output ready, init_done, rd_valid, rd_data);
`endif
endinterface

// File: rtl/ram_core.sv
// Raw storage: byte-lane synchronous write, registered 1-cycle read.
// RAM_PARITY_EN stores one parity bit per lane and flags mismatches on read.
module ram_core
    import ram_pkg::*;
#(
    parameter int unsigned LANES  = 1,
    parameter int unsigned ADDR_W = 10
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [LANES-1:0]        wr_en,
    input  logic                    rd_en,
    input  logic [ADDR_W-1:0]       addr,
    input  logic [LANES*LANE_W-1:0] wr_data,
`ifdef RAM_PARITY_EN
    input  logic [LANES-1:0]        wr_par,
    output logic                    rd_perr,
`endif
    output logic [LANES*LANE_W-1:0] rd_data
);
    localparam int unsigned DEPTH  = 2 ** ADDR_W;
    localparam int unsigned DATA_W = LANES * LANE_W;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(LANES); i++) begin
            if (wr_en[i]) mem[addr][i*LANE_W +: LANE_W] <= wr_data[i*LANE_W +: LANE_W];
        end
    end

    // Read register holds its value between reads; only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     rd_data <= '0;
        else if (rd_en) rd_data <= mem[addr];
    end

`ifdef RAM_PARITY_EN
    logic [LANES-1:0] pmem [DEPTH];
    logic [LANES-1:0] lane_err_c;

    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(LANES); i++) begin
            if (wr_en[i]) pmem[addr][i] <= wr_par[i];
        end
    end

    always_comb begin
        lane_err_c = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            lane_err_c[i] = parity8(mem[addr][i*LANE_W +: LANE_W]) ^ pmem[addr][i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     rd_perr <= 1'b0;
        else if (rd_en) rd_perr <= |lane_err_c;
    end
`endif

endmodule

// File: rtl/ram_sp_ctrl.sv
// Single-port RAM controller: zeroing init sweep, req/ready bus, 1- or 2-cycle read.
// RAM_PARITY_EN enables per-lane parity with write-side error injection.
module ram_sp_ctrl
    import ram_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    ram_sp_ctrl_if.slave  bus
);
    localparam int unsigned      LANES     = DATA_W / LANE_W;
    localparam int unsigned      DEPTH     = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t              state, state_n;
    logic [ADDR_W-1:0]   cnt, cnt_n;
    logic                ready_q, init_done_q;
    logic [LANES-1:0]    core_we;
    logic                core_rd;
    logic [ADDR_W-1:0]   core_addr;
    logic [DATA_W-1:0]   core_wdata;
    logic [DATA_W-1:0]   core_rdata;
    logic                v1;
`ifdef RAM_PARITY_EN
    logic [LANES-1:0]    core_wpar;
    logic                core_perr;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_INIT;
            cnt         <= '0;
            ready_q     <= 1'b0;
            init_done_q <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            ready_q     <= (state_n == ST_RUN);
            init_done_q <= (state_n == ST_RUN);
        end
    end

    // Next state plus storage port mux: the init sweep owns the port until done.
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        core_we    = '0;
        core_rd    = 1'b0;
        core_addr  = bus.addr;
        core_wdata = bus.wr_data;
`ifdef RAM_PARITY_EN
        core_wpar  = '0;
`endif
        case (state)
            ST_INIT: begin
                core_we    = '1;
                core_addr  = cnt;
                core_wdata = '0;
                cnt_n      = cnt + 1'b1;
                if (cnt == LAST_ADDR) state_n = ST_RUN;
                if (bus.clr) begin
                    state_n = ST_INIT;
                    cnt_n   = '0;
                end
            end
            ST_RUN: begin
                if (bus.clr) begin
                    state_n = ST_INIT;
                    cnt_n   = '0;
                end else if (bus.req && ready_q) begin
                    if (bus.we) core_we = bus.be;
                    else        core_rd = 1'b1;
`ifdef RAM_PARITY_EN
                    for (int i = 0; i < int'(LANES); i++) begin
                        core_wpar[i] = parity8(bus.wr_data[i*LANE_W +: LANE_W]) ^ bus.wr_perr_inj;
                    end
`endif
                end
            end
            default: state_n = ST_INIT;
        endcase
    end

    ram_core #(
        .LANES  (LANES),
        .ADDR_W (ADDR_W)
    ) u_core (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (core_we),
        .rd_en   (core_rd),
        .addr    (core_addr),
        .wr_data (core_wdata),
`ifdef RAM_PARITY_EN
        .wr_par  (core_wpar),
        .rd_perr (core_perr),
`endif
        .rd_data (core_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) v1 <= 1'b0;
        else        v1 <= core_rd;
    end

    assign bus.ready     = ready_q;
    assign bus.init_done = init_done_q;

    // Second output stage only captures on a valid read so rd_data holds otherwise.
    if (RD_LAT > RD_LAT_MIN) begin : g_lat2
        logic              v2;
        logic [DATA_W-1:0] d2;
`ifdef RAM_PARITY_EN
        logic              e2;
`endif
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v2 <= 1'b0;
                d2 <= '0;
`ifdef RAM_PARITY_EN
                e2 <= 1'b0;
`endif
            end else begin
                v2 <= v1;
                if (v1) begin
                    d2 <= core_rdata;
`ifdef RAM_PARITY_EN
                    e2 <= core_perr;
`endif
                end
            end
        end
        assign bus.rd_valid = v2;
        assign bus.rd_data  = d2;
`ifdef RAM_PARITY_EN
        assign bus.rd_perr  = e2;
`endif
    end else begin : g_lat1
        assign bus.rd_valid = v1;
        assign bus.rd_data  = core_rdata;
`ifdef RAM_PARITY_EN
        assign bus.rd_perr  = core_perr;
`endif
    end

endmodule

// File: tb/tb_ram_sp_ctrl.sv
// Bench for ram_sp_ctrl: RD_LAT=1 and RD_LAT=2 instances on identical stimulus,
// checked against a word-array model with a due-cycle queue of expected reads.
module tb_ram_sp_ctrl;
    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int BEW   = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ram_sp_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) b1 ();
    ram_sp_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) b2 ();

    ram_sp_ctrl #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
    ram_sp_ctrl #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(b2));

    typedef struct {
        int          due;
        logic [31:0] data;
        bit          perr;
        bit          tbl;
        logic [31:0] texp;
    } rd_t;

    typedef struct {
        bit          we;
        logic [3:0]  be;
        logic [3:0]  addr;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    logic [DW-1:0]  mmem [DEPTH];
    logic [BEW-1:0] mpar [DEPTH];
    bit             m_ready;
    int             m_rdy_at;
    int             cyc;
    rd_t            q1[$];
    rd_t            q2[$];
    logic [DW-1:0]  last [2];
    int             errors;
    int             checks;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int a = 0; a < DEPTH; a++) begin
            mmem[a] = '0;
            mpar[a] = '0;
        end
    endtask

    task automatic drive(input bit req, input bit we, input logic [3:0] be, input logic [3:0] addr,
                         input logic [31:0] data, input bit clr, input bit inj);
        b1.req = req; b1.we = we; b1.be = be; b1.addr = addr; b1.wr_data = data; b1.clr = clr;
        b2.req = req; b2.we = we; b2.be = be; b2.addr = addr; b2.wr_data = data; b2.clr = clr;
`ifdef RAM_PARITY_EN
        b1.wr_perr_inj = inj; b2.wr_perr_inj = inj;
`else
        if (inj) begin end
`endif
    endtask

    task automatic rd_check(input int lat);
        rd_t           e;
        bit            have;
        logic          v;
        logic [DW-1:0] d;
        string         tag;
        have = 1'b0;
        tag  = (lat == 1) ? "lat1" : "lat2";
        v    = (lat == 1) ? b1.rd_valid : b2.rd_valid;
        d    = (lat == 1) ? b1.rd_data  : b2.rd_data;
        if (lat == 1) begin
            if (q1.size() > 0 && q1[0].due == cyc) begin e = q1.pop_front(); have = 1'b1; end
        end else begin
            if (q2.size() > 0 && q2[0].due == cyc) begin e = q2.pop_front(); have = 1'b1; end
        end
        check({tag, " rd_valid"}, 32'(v), 32'(have));
        if (have) begin
            check({tag, " rd_data"}, d, e.data);
            if (e.tbl) check({tag, " table rd_data"}, d, e.texp);
            last[lat-1] = e.data;
`ifdef RAM_PARITY_EN
            check({tag, " rd_perr"}, 32'((lat == 1) ? b1.rd_perr : b2.rd_perr), 32'(e.perr));
`endif
        end else begin
            check({tag, " rd_data hold"}, d, last[lat-1]);
        end
    endtask

    // One clock: drive, advance the model across the edge, then compare.
    task automatic step(input bit req, input bit we, input logic [3:0] be, input logic [3:0] addr,
                        input logic [31:0] data, input bit clr, input bit inj,
                        input bit tbl, input logic [31:0] texp);
        rd_t e;
        drive(req, we, be, addr, data, clr, inj);
        @(posedge clk);
        cyc++;
        if (clr) begin
            model_clear();
            m_rdy_at = cyc + DEPTH;
        end else if (m_ready && req) begin
            if (we) begin
                for (int i = 0; i < BEW; i++) begin
                    if (be[i]) begin
                        mmem[addr][i*8 +: 8] = data[i*8 +: 8];
                        mpar[addr][i]        = inj;
                    end
                end
            end else begin
                e.data = mmem[addr];
                e.perr = |mpar[addr];
                e.tbl  = tbl;
                e.texp = texp;
                e.due  = cyc;
                q1.push_back(e);
                e.due  = cyc + 1;
                q2.push_back(e);
            end
        end
        m_ready = (cyc >= m_rdy_at);
        #1;
        check("lat1 ready", 32'(b1.ready), 32'(m_ready));
        check("lat2 ready", 32'(b2.ready), 32'(m_ready));
        check("lat1 init_done", 32'(b1.init_done), 32'(m_ready));
        check("lat2 init_done", 32'(b2.init_done), 32'(m_ready));
        rd_check(1);
        rd_check(2);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic read(input logic [3:0] addr, input logic [31:0] exp);
        step(1'b1, 1'b0, 4'h0, addr, 32'h0, 1'b0, 1'b0, 1'b1, exp);
    endtask

    task automatic wait_ready(input string name, input int expect_cycles);
        int n;
        n = 0;
        while (n < 100 && !b1.ready) begin
            idle(1);
            n++;
        end
        check(name, 32'(n), 32'(expect_cycles));
    endtask

    // Asserted right after a negedge, so any read still in flight is killed.
    task automatic do_reset();
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 1'b0);
        #1;
        check("reset lat1 ready", 32'(b1.ready), 32'h0);
        check("reset lat2 init_done", 32'(b2.init_done), 32'h0);
        check("reset lat1 rd_valid", 32'(b1.rd_valid), 32'h0);
        check("reset lat2 rd_valid", 32'(b2.rd_valid), 32'h0);
        check("reset lat1 rd_data", b1.rd_data, 32'h0);
        check("reset lat2 rd_data", b2.rd_data, 32'h0);
        q1.delete();
        q2.delete();
        last[0] = '0;
        last[1] = '0;
        model_clear();
        m_ready = 1'b0;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        rst_n    = 1'b1;
        m_rdy_at = cyc + DEPTH;
    endtask

    vec_t tbl [15];

    initial begin
        errors = 0;
        checks = 0;
        cyc    = 0;
        tbl[0]  = '{1'b1, 4'hF, 4'd5, 32'hAABBCCDD, 32'h0};
        tbl[1]  = '{1'b1, 4'h5, 4'd5, 32'h11223344, 32'h0};
        tbl[2]  = '{1'b0, 4'h0, 4'd5, 32'h0,        32'hAA22CC44};
        tbl[3]  = '{1'b1, 4'hF, 4'd1, 32'h10,       32'h0};
        tbl[4]  = '{1'b1, 4'hF, 4'd2, 32'h20,       32'h0};
        tbl[5]  = '{1'b1, 4'hF, 4'd3, 32'h30,       32'h0};
        tbl[6]  = '{1'b0, 4'h0, 4'd1, 32'h0,        32'h10};
        tbl[7]  = '{1'b0, 4'h0, 4'd2, 32'h0,        32'h20};
        tbl[8]  = '{1'b0, 4'h0, 4'd3, 32'h0,        32'h30};
        tbl[9]  = '{1'b1, 4'hF, 4'd7, 32'h5A,       32'h0};
        tbl[10] = '{1'b0, 4'h0, 4'd7, 32'h0,        32'h5A};
        tbl[11] = '{1'b1, 4'h0, 4'd7, 32'hFFFFFFFF, 32'h0};
        tbl[12] = '{1'b0, 4'h0, 4'd7, 32'h0,        32'h5A};
        tbl[13] = '{1'b1, 4'h2, 4'd7, 32'h0000AB00, 32'h0};
        tbl[14] = '{1'b0, 4'h0, 4'd7, 32'h0,        32'h0000AB5A};

        do_reset();
        wait_ready("init ready latency", DEPTH);
        for (int a = 0; a < DEPTH; a++) read(4'(a), 32'h0);
        idle(3);

        for (int i = 0; i < 15; i++) begin
            step(1'b1, tbl[i].we, tbl[i].be, tbl[i].addr, tbl[i].data, 1'b0, 1'b0, !tbl[i].we, tbl[i].exp);
        end
        idle(3);

        // clr with a read in flight and a simultaneous write that must be dropped
        read(4'd1, 32'h10);
        step(1'b1, 1'b1, 4'hF, 4'd3, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 32'h0);
        wait_ready("clr ready latency", DEPTH);
        read(4'd3, 32'h0);
        read(4'd5, 32'h0);
        idle(3);

        // clr during the sweep restarts it
        step(1'b0, 1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
        idle(5);
        step(1'b0, 1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
        wait_ready("clr in init latency", DEPTH);

`ifdef RAM_PARITY_EN
        step(1'b1, 1'b1, 4'h1, 4'd9, 32'h3C, 1'b0, 1'b1, 1'b0, 32'h0);
        read(4'd9, 32'h3C);
        idle(2);
        check("perr injected", 32'(b2.rd_perr), 32'h1);
        step(1'b1, 1'b1, 4'h1, 4'd9, 32'h3C, 1'b0, 1'b0, 1'b0, 32'h0);
        read(4'd9, 32'h3C);
        idle(2);
        check("perr cleared", 32'(b2.rd_perr), 32'h0);
`endif

        // reset with a read still in the pipeline: its rd_valid must not appear
        step(1'b1, 1'b1, 4'hF, 4'd4, 32'h12345678, 1'b0, 1'b0, 1'b0, 32'h0);
        read(4'd4, 32'h12345678);
        do_reset();
        wait_ready("post-reset ready latency", DEPTH);
        read(4'd4, 32'h0);
        idle(3);

        for (int k = 0; k < 400; k++) begin
            step(($urandom_range(0, 3) != 0), 1'($urandom), 4'($urandom), 4'($urandom), $urandom,
                 ($urandom_range(0, 59) == 0), 1'($urandom), 1'b0, 32'h0);
        end
        idle(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
